// File: rtl/adc_pkg.sv
// Shared ADC definitions: controller state encoding and the default result width,
// also imported by the downstream decode stage.
package adc_pkg;

  localparam int unsigned ADC_BITS = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track/hold sequencing, binary search of
// the DAC trial code against the clocked comparator, registered result with done strobe.
module sar_adc_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned N             = ADC_BITS,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cont,
  input  logic         cmp_in,
  output logic         sample_hold,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] code
);

  localparam int unsigned CNT_MAX = max_u(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] TOP_IDX     = IW'(N - 1);

  sar_state_t    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [N-1:0]  result;
  logic [N-1:0]  resolved;

  // Bits at and below idx are zero in result, so OR-ing the comparator decides bit idx.
  assign resolved = result | (N'(cmp_in) << idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      result      <= '0;
      sample_hold <= 1'b0;
      dac_code    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      code        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SAMPLE;
            sample_hold <= 1'b1;
            busy        <= 1'b1;
            dac_code    <= '0;
            cnt         <= '0;
          end
        end

        SAMPLE: begin
          result <= '0;
          if (cnt == SAMPLE_LAST) begin
            state       <= CONVERT;
            sample_hold <= 1'b0;
            cnt         <= '0;
            idx         <= TOP_IDX;
            dac_code    <= N'(1) << TOP_IDX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        CONVERT: begin
          if (cnt == SETTLE_LAST) begin
            cnt    <= '0;
            result <= resolved;
            if (idx == '0) begin
              state    <= DONE;
              code     <= resolved;
              done     <= 1'b1;
              busy     <= 1'b0;
              dac_code <= '0;
            end else begin
              idx      <= idx - IW'(1);
              dac_code <= resolved | (N'(1) << (idx - IW'(1)));
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          // start and cont together still launch exactly one conversion
          if (start || cont) begin
            state       <= SAMPLE;
            sample_hold <= 1'b1;
            busy        <= 1'b1;
            dac_code    <= '0;
            cnt         <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: ideal registered comparator, expected-code
// scoreboard popped on each done strobe, plus latency, trial-sequence and reset checks.
module tb_sar_adc_ctrl;
  import adc_pkg::*;

  localparam int unsigned N = ADC_BITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cont;
  logic         cmp_in;
  logic         sample_hold;
  logic [N-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [N-1:0] code;

  int vin_code;
  int cyc;
  int done_cnt;
  int tests;
  int fails;
  int prev_code;
  int exp_code[$];
  int done_cycs[$];
  int trace[$];

  sar_adc_ctrl #(.N(N), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .cmp_in(cmp_in),
    .sample_hold(sample_hold), .dac_code(dac_code), .busy(busy),
    .done(done), .code(code)
  );

  always #5 clk = ~clk;

  // Ideal comparator, registered like the real clocked one
  always @(posedge clk) cmp_in <= (vin_code >= int'(dac_code));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard and trace monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        done_cycs.push_back(cyc);
        if (exp_code.size() == 0) check("spurious_done", 1, 0);
        else check("code", int'(code), exp_code.pop_front());
      end
      if (!done && int'(code) != prev_code) check("code_stable", int'(code), prev_code);
      if (busy && !sample_hold && (trace.size() == 0 || trace[$] != int'(dac_code)))
        trace.push_back(int'(dac_code));
    end
    prev_code = int'(code);
  end

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) return;
    end
    check("done_timeout", done_cnt, target);
  endtask

  task automatic run_conv(input int vin, input bit pulse5);
    int e0;
    int base;
    int v;
    int trial;
    int k;
    vin_code = vin;
    exp_code.push_back(vin);
    trace.delete();
    base  = done_cnt;
    start = 1'b1;
    e0    = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (pulse5) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(base + 1, 40);
    if (done_cnt > base) check("latency", done_cycs[$] - e0, 12);
    check("busy_after", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    check("trace_len", trace.size(), N);
    v = 0;
    k = 0;
    for (int b = N - 1; b >= 0; b--) begin
      trial = v | (1 << b);
      if (k < trace.size()) check("trial", trace[k], trial);
      if (vin >= trial) v = trial;
      k++;
    end
    if (pulse5) begin
      repeat (15) @(posedge clk);
      #1 check("no_extra_done", done_cnt, base + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int base;
    tests = 0; fails = 0; cyc = 0; done_cnt = 0; prev_code = 0;
    vin_code = 0; start = 1'b0; cont = 1'b0; rst = 1'b1;
    #1;
    check("rst_sample_hold", int'(sample_hold), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dac", int'(dac_code), 0);
    check("rst_code", int'(code), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic conversion and both extremes
    run_conv(19, 1'b0);
    check("code_19", int'(code), 19);
    run_conv(0, 1'b0);
    run_conv(31, 1'b0);
    // Extra start during conversion is ignored
    run_conv(10, 1'b1);
    check("code_held", int'(code), 10);

    // Continuous mode: 7 then 25, 13 cycles apart
    base = done_cnt;
    exp_code.push_back(7);
    exp_code.push_back(25);
    vin_code = 7;
    cont  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(base + 1, 40);
    vin_code = 25;
    cont = 1'b0;
    wait_done(base + 2, 40);
    if (done_cnt >= base + 2)
      check("cont_period", done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2], 13);
    repeat (20) @(posedge clk);
    #1 check("cont_stops", done_cnt, base + 2);

    // Reset mid-conversion discards the partial result
    run_conv(12, 1'b0);
    base = done_cnt;
    vin_code = 20;
    start = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < e0 + 8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("abort_code", int'(code), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_dac", int'(dac_code), 0);
    check("abort_sh", int'(sample_hold), 0);
    check("abort_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, base);
    check("idle_wait", int'(busy), 0);
    run_conv(20, 1'b0);

    // start held high: back-to-back conversions every 13 cycles
    base = done_cnt;
    vin_code = 31;
    repeat (3) exp_code.push_back(31);
    start = 1'b1;
    wait_done(base + 2, 40);
    start = 1'b0;
    wait_done(base + 3, 40);
    if (done_cnt >= base + 3) begin
      check("held_period_a", done_cycs[done_cycs.size()-2] - done_cycs[done_cycs.size()-3], 13);
      check("held_period_b", done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2], 13);
    end
    repeat (20) @(posedge clk);
    #1;
    check("held_stops", done_cnt, base + 3);
    check("sb_empty", exp_code.size(), 0);
    check("final_code", int'(code), 31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
